// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: IDLE/BUY/PAY/CHANGE flow, money registers and display value.
// Optional inactivity abort in BUY/PAY is built when VEND_TIMEOUT_EN is defined.
module vend_txn_ctrl #(
    parameter int unsigned ITEM_NUM      = 4,
    parameter int unsigned PRICE_BASE    = 3,
    parameter int unsigned PRICE_STEP    = 2,
    parameter int unsigned COIN_A        = 1,
    parameter int unsigned COIN_B        = 5,
    parameter int unsigned TIMEOUT_TICKS = 5,
    parameter int unsigned CHANGE_TICKS  = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  key,
    input  logic        flag_2s,
    output logic [16:0] show_val,
    output logic        flag_charge,
    output logic        vend_ok,
    output logic [1:0]  state_o,
    output logic [1:0]  item_o
);
    localparam int unsigned MW = 5;
    localparam int unsigned SW = 17;
    localparam int unsigned CW = $clog2(CHANGE_TICKS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUY    = 2'd1;
    localparam logic [1:0] S_PAY    = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    logic [1:0]    state, state_n;
    logic [1:0]    item, item_n;
    logic [MW-1:0] money_pay, money_pay_n;
    logic [MW-1:0] money_paid, money_paid_n;
    logic [MW-1:0] money_charge, money_charge_n;
    logic [CW-1:0] chg_cnt, chg_cnt_n;
    logic [SW-1:0] show_n;
    logic          vend_n;
    logic          accepted;
    logic          k0, k1, k2, k3;
    logic [MW:0]   paid_sum;
    logic [MW-1:0] paid_sat;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] to_cnt, to_cnt_n;
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_TICKS;
`endif

    function automatic logic [MW-1:0] price(input logic [1:0] idx);
        return MW'(PRICE_BASE) + MW'(idx) * MW'(PRICE_STEP);
    endfunction

    // Only the highest-priority key bit survives
    assign k3 = key[3];
    assign k2 = key[2] & ~key[3];
    assign k1 = key[1] & ~key[3] & ~key[2];
    assign k0 = key[0] & ~key[3] & ~key[2] & ~key[1];

    // Coin addition saturates at the 5-bit maximum
    always_comb begin
        paid_sum = {1'b0, money_paid} + (k2 ? (MW+1)'(COIN_B) : (MW+1)'(COIN_A));
        paid_sat = paid_sum[MW] ? {MW{1'b1}} : paid_sum[MW-1:0];
    end

    // Next-state, money and output computation
    always_comb begin
        state_n        = state;
        item_n         = item;
        money_pay_n    = money_pay;
        money_paid_n   = money_paid;
        money_charge_n = money_charge;
        chg_cnt_n      = chg_cnt;
        vend_n         = 1'b0;
        accepted       = 1'b0;
        show_n         = '0;

        case (state)
            S_IDLE: begin
                if (k0) begin
                    state_n  = S_BUY;
                    item_n   = 2'd0;
                    accepted = 1'b1;
                end
            end
            S_BUY: begin
                if (k3) begin
                    state_n  = S_IDLE;
                    accepted = 1'b1;
                end else if (k1) begin
                    state_n      = S_PAY;
                    money_pay_n  = price(item);
                    money_paid_n = '0;
                    accepted     = 1'b1;
                end else if (k0) begin
                    item_n   = (item == 2'(ITEM_NUM - 1)) ? 2'd0 : item + 2'd1;
                    accepted = 1'b1;
                end
            end
            S_PAY: begin
                if (k3) begin
                    state_n        = S_CHANGE;
                    money_charge_n = money_paid;
                    accepted       = 1'b1;
                end else if (k1 || k2) begin
                    money_paid_n = paid_sat;
                    accepted     = 1'b1;
                    if (paid_sat >= money_pay) begin
                        state_n        = S_CHANGE;
                        money_charge_n = paid_sat - money_pay;
                        vend_n         = 1'b1;
                    end
                end
            end
            default: begin
                if (flag_2s) begin
                    if ((CW+1)'(chg_cnt) + (CW+1)'(1) >= (CW+1)'(CHANGE_TICKS)) begin
                        state_n        = S_IDLE;
                        money_pay_n    = '0;
                        money_paid_n   = '0;
                        money_charge_n = '0;
                    end else begin
                        chg_cnt_n = chg_cnt + CW'(1);
                    end
                end
            end
        endcase

`ifdef VEND_TIMEOUT_EN
        to_cnt_n = to_cnt;
        if (accepted || state_n != state) begin
            to_cnt_n = '0;
        end else if (flag_2s && (state == S_BUY || state == S_PAY)) begin
            if ((TW+1)'(to_cnt) + (TW+1)'(1) >= (TW+1)'(TIMEOUT_TICKS)) begin
                to_cnt_n = '0;
                if (state == S_BUY) begin
                    state_n = S_IDLE;
                end else begin
                    state_n        = S_CHANGE;
                    money_charge_n = money_paid;
                end
            end else begin
                to_cnt_n = to_cnt + TW'(1);
            end
        end
`endif

        if (state_n != state) begin
            chg_cnt_n = '0;
        end

        case (state_n)
            S_IDLE:   show_n = '0;
            S_BUY:    show_n = SW'(price(item_n));
            S_PAY:    show_n = SW'(money_pay_n - money_paid_n);
            default:  show_n = SW'(money_charge_n);
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            item         <= 2'd0;
            money_pay    <= '0;
            money_paid   <= '0;
            money_charge <= '0;
            chg_cnt      <= '0;
            show_val     <= '0;
            flag_charge  <= 1'b0;
            vend_ok      <= 1'b0;
        end else begin
            state        <= state_n;
            item         <= item_n;
            money_pay    <= money_pay_n;
            money_paid   <= money_paid_n;
            money_charge <= money_charge_n;
            chg_cnt      <= chg_cnt_n;
            show_val     <= show_n;
            flag_charge  <= (state_n == S_CHANGE);
            vend_ok      <= vend_n;
        end
    end

`ifdef VEND_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_n;
        end
    end
`endif

    assign state_o = state;
    assign item_o  = item;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl; expected tuples {state,item,show,charge,ok} are hand-computed.
module tb_vend_txn_ctrl;
    logic        clk;
    logic        rstn;
    logic [3:0]  key;
    logic        flag_2s;
    logic [16:0] show_val;
    logic        flag_charge;
    logic        vend_ok;
    logic [1:0]  state_o;
    logic [1:0]  item_o;

    int vectors;
    int miscompares;

    vend_txn_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .key        (key),
        .flag_2s    (flag_2s),
        .show_val   (show_val),
        .flag_charge(flag_charge),
        .vend_ok    (vend_ok),
        .state_o    (state_o),
        .item_o     (item_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] pk(input int s, input int i, input int v, input int c, input int o);
        return {2'(s), 2'(i), 17'(v), 1'(c), 1'(o)};
    endfunction

    function automatic logic [22:0] obs();
        return {state_o, item_o, show_val, flag_charge, vend_ok};
    endfunction

    // One clock with key/tick applied for that cycle; outputs are sampled 1ns after the edge
    task automatic step(input logic [3:0] k, input logic f);
        @(negedge clk);
        key     = k;
        flag_2s = f;
        @(posedge clk);
        #1;
        key     = 4'd0;
        flag_2s = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; key = 4'd0; flag_2s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_idle_ignore();
        step(4'b0010, 1'b0); step(4'b0100, 1'b0); step(4'b1000, 1'b1);
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL idle_ignore: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_select_confirm();
        step(4'b0001, 1'b0);
        vectors++;
        if (obs() !== pk(1, 0, 3, 0, 0)) begin
            miscompares++;
            $display("FAIL enter_buy: got %h want %h", obs(), pk(1, 0, 3, 0, 0));
        end
        step(4'b0001, 1'b0);
        vectors++;
        if (obs() !== pk(1, 1, 5, 0, 0)) begin
            miscompares++;
            $display("FAIL next_item: got %h want %h", obs(), pk(1, 1, 5, 0, 0));
        end
        step(4'b0100, 1'b0);
        vectors++;
        if (obs() !== pk(1, 1, 5, 0, 0)) begin
            miscompares++;
            $display("FAIL buy_coinb_ignored: got %h want %h", obs(), pk(1, 1, 5, 0, 0));
        end
        step(4'b0010, 1'b0);
        vectors++;
        if (obs() !== pk(2, 1, 5, 0, 0)) begin
            miscompares++;
            $display("FAIL confirm_pay: got %h want %h", obs(), pk(2, 1, 5, 0, 0));
        end
    endtask

    task automatic test_exact_pay();
        step(4'b0100, 1'b0);
        vectors++;
        if (obs() !== pk(3, 1, 0, 1, 1)) begin
            miscompares++;
            $display("FAIL exact_change: got %h want %h", obs(), pk(3, 1, 0, 1, 1));
        end
        step(4'b1111, 1'b0);
        vectors++;
        if (obs() !== pk(3, 1, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL change_hold: got %h want %h", obs(), pk(3, 1, 0, 1, 0));
        end
        step(4'b0000, 1'b1);
        vectors++;
        if (obs() !== pk(0, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL change_exit: got %h want %h", obs(), pk(0, 1, 0, 0, 0));
        end
    endtask

    task automatic test_overpay();
        step(4'b0001, 1'b0);
        repeat (3) step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        vectors++;
        if (obs() !== pk(2, 3, 9, 0, 0)) begin
            miscompares++;
            $display("FAIL item3_pay: got %h want %h", obs(), pk(2, 3, 9, 0, 0));
        end
        step(4'b0100, 1'b0);
        vectors++;
        if (obs() !== pk(2, 3, 4, 0, 0)) begin
            miscompares++;
            $display("FAIL first_coinb: got %h want %h", obs(), pk(2, 3, 4, 0, 0));
        end
        step(4'b0100, 1'b0);
        vectors++;
        if (obs() !== pk(3, 3, 1, 1, 1)) begin
            miscompares++;
            $display("FAIL overpay_change: got %h want %h", obs(), pk(3, 3, 1, 1, 1));
        end
        step(4'b0000, 1'b1);
    endtask

    task automatic test_refund();
        step(4'b0001, 1'b0);
        vectors++;
        if (obs() !== pk(1, 0, 3, 0, 0)) begin
            miscompares++;
            $display("FAIL reenter_item0: got %h want %h", obs(), pk(1, 0, 3, 0, 0));
        end
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        vectors++;
        if (obs() !== pk(2, 0, 2, 0, 0)) begin
            miscompares++;
            $display("FAIL coina: got %h want %h", obs(), pk(2, 0, 2, 0, 0));
        end
        step(4'b0001, 1'b0);
        vectors++;
        if (obs() !== pk(2, 0, 2, 0, 0)) begin
            miscompares++;
            $display("FAIL pay_select_ignored: got %h want %h", obs(), pk(2, 0, 2, 0, 0));
        end
        step(4'b1000, 1'b0);
        vectors++;
        if (obs() !== pk(3, 0, 1, 1, 0)) begin
            miscompares++;
            $display("FAIL refund: got %h want %h", obs(), pk(3, 0, 1, 1, 0));
        end
        step(4'b0000, 1'b1);
    endtask

    task automatic test_priority();
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b1110, 1'b0);
        vectors++;
        if (obs() !== pk(3, 0, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL cancel_wins: got %h want %h", obs(), pk(3, 0, 0, 1, 0));
        end
        step(4'b0000, 1'b1);
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL zero_refund_exit: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_wrap_cancel();
        step(4'b0001, 1'b0);
        repeat (3) step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        vectors++;
        if (obs() !== pk(1, 0, 3, 0, 0)) begin
            miscompares++;
            $display("FAIL item_wrap: got %h want %h", obs(), pk(1, 0, 3, 0, 0));
        end
        step(4'b1000, 1'b0);
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL buy_cancel: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
        end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        step(4'b0001, 1'b0);
        repeat (4) step(4'b0000, 1'b1);
        vectors++;
        if (obs() !== pk(1, 0, 3, 0, 0)) begin
            miscompares++;
            $display("FAIL buy_tick4: got %h want %h", obs(), pk(1, 0, 3, 0, 0));
        end
        step(4'b0000, 1'b1);
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL buy_timeout: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
        end
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        repeat (3) step(4'b0000, 1'b1);
        step(4'b0010, 1'b1);
        vectors++;
        if (obs() !== pk(2, 0, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL key_on_tick4: got %h want %h", obs(), pk(2, 0, 1, 0, 0));
        end
        repeat (4) step(4'b0000, 1'b1);
        vectors++;
        if (obs() !== pk(2, 0, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL pay_restart: got %h want %h", obs(), pk(2, 0, 1, 0, 0));
        end
        step(4'b0000, 1'b1);
        vectors++;
        if (obs() !== pk(3, 0, 2, 1, 0)) begin
            miscompares++;
            $display("FAIL pay_timeout: got %h want %h", obs(), pk(3, 0, 2, 1, 0));
        end
        step(4'b0000, 1'b1);
    endtask
`else
    task automatic test_no_timeout();
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        repeat (10) step(4'b0000, 1'b1);
        vectors++;
        if (obs() !== pk(2, 0, 2, 0, 0)) begin
            miscompares++;
            $display("FAIL pay_waits: got %h want %h", obs(), pk(2, 0, 2, 0, 0));
        end
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b1);
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL no_timeout_exit: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
        end
    endtask
`endif

    task automatic test_reset_midway();
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #2;
        vectors++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_idle_ignore();
        test_select_confirm();
        test_exact_pay();
        test_overpay();
        test_refund();
        test_priority();
        test_wrap_cancel();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
- Transaction sequencer for the vending machine: owns the IDLE/BUY/PAY/CHANGE flow, price, paid and change registers.
- Produces the value the 6-digit scanned 7-segment display shows, plus the change flag.
- Sits between the debounced key block and the display scanner; consumes the 2 s tick for timeouts and change hold.

Parameters:
- ITEM_NUM, 4: number of selectable items. Item index is 2 bits, so max 4.
- PRICE_BASE, 3: price of item 0, in coin units.
- PRICE_STEP, 2: price increment per item index. Default prices are 3/5/7/9.
- COIN_A, 1: value added by key[1] in PAY.
- COIN_B, 5: value added by key[2] in PAY.
- TIMEOUT_TICKS, 5: flag_2s ticks of inactivity before abort (10 s).
- CHANGE_TICKS, 1: flag_2s ticks CHANGE is held.
- Legal range: PRICE_BASE + (ITEM_NUM-1)*PRICE_STEP + COIN_B <= 31.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- key  in  4  single-cycle debounced key pulses. [0] select/next, [1] confirm or coin A, [2] coin B, [3] cancel.
- flag_2s  in  1  one-cycle tick every 2 s.
- show_val  out  17  registered value for display, zero-extended from 5 bits.
- flag_charge  out  1  registered, high while in CHANGE.
- vend_ok  out  1  registered one-cycle pulse on successful purchase.
- state_o  out  2  current state: 0 IDLE, 1 BUY, 2 PAY, 3 CHANGE.
- item_o  out  2  currently selected item index.

Behaviour:
- Reset (async, rstn low): state IDLE, item 0, money_pay/money_paid/money_charge 0, timers 0, show_val 0, flag_charge 0, vend_ok 0, state_o 0, item_o 0. Reset mid-transaction discards all money; no refund indication.
- Key priority when several bits are set in one cycle: key[3] > key[2] > key[1] > key[0]. Only the highest is acted on; the rest are dropped.
- Latency: all outputs are registered and update on the edge that applies the transition. show_val, state_o and flag_charge change in the same cycle.
- IDLE:
  - show_val = 0.
  - key[0] -> BUY with item 0. Other keys are ignored.
- BUY:
  - show_val = price(item) = PRICE_BASE + item*PRICE_STEP.
  - key[0]: item increments, wrapping ITEM_NUM-1 -> 0.
  - key[1] -> PAY; money_pay = price(item), money_paid = 0.
  - key[3] -> IDLE.
  - key[2] is ignored.
- PAY:
  - show_val = money_pay - money_paid (remaining amount).
  - key[1] adds COIN_A; key[2] adds COIN_B.
  - If the new paid >= money_pay -> CHANGE: money_charge = paid - money_pay, vend_ok pulses.
  - Exact payment enters CHANGE with change 0.
  - key[3] -> CHANGE (refund): money_charge = money_paid, no vend_ok. Cancel with paid 0 still passes through CHANGE showing 0.
  - key[0] is ignored.
- CHANGE:
  - show_val = money_charge; flag_charge = 1. All keys are ignored.
  - A counter counts flag_2s ticks. On the CHANGE_TICKS-th tick -> IDLE, clearing money registers and flag_charge.
  - Hold time is therefore (CHANGE_TICKS-1)*2 s to CHANGE_TICKS*2 s.
- Arithmetic: money registers are 5 bits. money_paid addition saturates at 31, which is unreachable within the legal range. Subtraction never underflows by construction.
- Timers: the inactivity counter clears on any accepted key and on every state change.
  - A flag_2s tick in the same cycle as an accepted key counts as activity; the counter clears and does not increment.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined: in BUY or PAY, reaching TIMEOUT_TICKS flag_2s ticks without an accepted key aborts.
  - BUY aborts to IDLE.
  - PAY aborts to CHANGE as a refund of money_paid, without vend_ok.
- Not defined: no inactivity counter is built; BUY and PAY wait indefinitely. CHANGE hold is unaffected.

Test Plan:
- Reset, then key[0], key[0], key[1]: state_o goes 1 then 2, item_o=1, show_val 3 -> 5 (BUY) -> 5 (PAY).
- Item 1 in PAY: key[2] -> state 3, show_val=0, flag_charge=1, vend_ok pulses once. After 1 flag_2s -> IDLE, show_val=0, flag_charge=0.
- Item 3 (price 9): key[2], then key[2] -> show_val 4 after the first coin, then CHANGE showing 1, vend_ok pulses.
- Item 0: key[1] confirms into PAY, one key[1] coin (show_val 2), then key[3] -> CHANGE, show_val=1, no vend_ok.
- key=4'b1110 in PAY with item 0: cancel wins -> refund CHANGE, paid unchanged. In BUY, key[0] from item 3 wraps to item 0.
- With VEND_TIMEOUT_EN: PAY with paid=1, 5 flag_2s ticks and no keys -> CHANGE showing 1. A key on tick 4 restarts the count. Without the macro, state stays PAY after 10 ticks.
